audio_capture_fifo: RTL and testbench



---
 rtl/audio_capture_fifo.sv | 147 ++++++++++++++
 tb/tb_audio_capture_fifo.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_capture_fifo.sv
// audio_capture_fifo
//   Buffers per-sample ADC captures from the CODEC audio driver in a FIFO and
//   presents them downstream on a first-word-fall-through valid/ready stream.
//   Also returns a DAC sample pair to the driver: a one-sample-delayed copy of
//   the ADC pair (loopback) or mid-scale silence.
//
// Configuration macro:
//   AUDIO_CAPTURE_MONO_MIX_EN  defined: stored sample = (adc_left + adc_right) >> 1
//                              undefined: stored sample = adc_left
//
// Ports:
//   CLOCK_50        in   system clock, rising edge
//   reset           in   synchronous active-high reset
//   advance         in   one-cycle sample strobe from the driver
//   adc_left/right  in   ADC samples, valid while advance=1
//   dac_left/right  out  DAC samples to the driver, change only on advance
//   loopback_en     in   1 = echo ADC to DAC, 0 = mid-scale silence
//   out_data        out  FIFO head sample (holds last value when empty)
//   out_valid       out  FIFO non-empty
//   out_ready       in   downstream accepts out_data
//   level           out  occupancy, 0..DEPTH
//   overflow_count  out  dropped-sample count, saturating
//   flush           in   synchronous clear of FIFO contents (counter kept)
module audio_capture_fifo #(
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned OVF_W  = 16
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              advance,
  input  logic [WIDTH-1:0]  adc_left,
  input  logic [WIDTH-1:0]  adc_right,
  output logic [WIDTH-1:0]  dac_left,
  output logic [WIDTH-1:0]  dac_right,
  input  logic              loopback_en,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   level,
  output logic [OVF_W-1:0]  overflow_count,
  input  logic              flush
);

  localparam logic [ADDR_W:0]  LevelFull = (ADDR_W+1)'(DEPTH);
  localparam logic [WIDTH-1:0] MidScale  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [OVF_W-1:0]  ovf_q, ovf_d;
  logic [WIDTH-1:0]  dac_l_q, dac_l_d;
  logic [WIDTH-1:0]  dac_r_q, dac_r_d;

  logic [WIDTH-1:0]  sample;
  logic              pop, full, push, drop, wr_en;

`ifdef AUDIO_CAPTURE_MONO_MIX_EN
  // One extra bit keeps the sum exact; dropping the LSB halves it.
  logic [WIDTH:0] mix_sum;
  assign mix_sum = {1'b0, adc_left} + {1'b0, adc_right};
  assign sample  = mix_sum[WIDTH:1];
`else
  assign sample = adc_left;
`endif

  always_comb begin
    pop  = valid_q & out_ready;
    full = (level_q == LevelFull);
    // A pop frees the head slot this cycle, so a full FIFO still accepts.
    push = advance & (~full | pop);
    drop = advance & full & ~pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    data_d   = data_q;
    wr_en    = 1'b0;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      wr_en = push;
      if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      if (push && !pop)      level_d = level_q + (ADDR_W+1)'(1);
      else if (pop && !push) level_d = level_q - (ADDR_W+1)'(1);
      if (drop && (ovf_q != '1)) ovf_d = ovf_q + OVF_W'(1);
    end

    valid_d = (level_d != '0);
    // The new head is the incoming sample only when it lands at the next read
    // slot, i.e. the FIFO was empty (or held one entry being popped).
    if (valid_d) begin
      data_d = (push && (wr_ptr_q == rd_ptr_d)) ? sample : mem[rd_ptr_d];
    end

    dac_l_d = dac_l_q;
    dac_r_d = dac_r_q;
    if (advance) begin
      dac_l_d = loopback_en ? adc_left  : MidScale;
      dac_r_d = loopback_en ? adc_right : MidScale;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      ovf_q    <= '0;
      dac_l_q  <= MidScale;
      dac_r_q  <= MidScale;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      dac_l_q  <= dac_l_d;
      dac_r_q  <= dac_r_d;
    end
  end

  // Storage needs no reset; entries are only read once written.
  always_ff @(posedge CLOCK_50) begin
    if (wr_en && !reset) mem[wr_ptr_q] <= sample;
  end

  assign dac_left       = dac_l_q;
  assign dac_right      = dac_r_q;
  assign out_data       = data_q;
  assign out_valid      = valid_q;
  assign level          = level_q;
  assign overflow_count = ovf_q;

endmodule

// File: tb/tb_audio_capture_fifo.sv
module tb_audio_capture_fifo;
  localparam int WIDTH  = 24;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int OVF_W  = 16;
  localparam logic [23:0] MID = 24'h800000;

  logic              CLOCK_50 = 1'b0;
  logic              reset = 1'b1;
  logic              advance = 1'b0;
  logic [WIDTH-1:0]  adc_left = '0, adc_right = '0;
  logic [WIDTH-1:0]  dac_left, dac_right;
  logic              loopback_en = 1'b0;
  logic [WIDTH-1:0]  out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ADDR_W:0]   level;
  logic [OVF_W-1:0]  overflow_count;
  logic              flush = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a queue of stored samples plus the observable registers.
  logic [23:0] mq[$];
  int          m_ovf = 0;
  logic [23:0] m_data = '0;
  logic [23:0] m_dl = MID, m_dr = MID;

  always #10 CLOCK_50 = ~CLOCK_50;

  audio_capture_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .OVF_W(OVF_W)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .advance(advance),
    .adc_left(adc_left), .adc_right(adc_right),
    .dac_left(dac_left), .dac_right(dac_right), .loopback_en(loopback_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .overflow_count(overflow_count), .flush(flush)
  );

  function automatic logic [23:0] exp_sample(input logic [23:0] l, input logic [23:0] r);
`ifdef AUDIO_CAPTURE_MONO_MIX_EN
    return 24'((int'(l) + int'(r)) / 2);
`else
    return l;
`endif
  endfunction

  task automatic model_step();
    bit pop;
    if (reset) begin
      mq.delete();
      m_ovf = 0; m_data = '0; m_dl = MID; m_dr = MID;
    end else begin
      pop = (mq.size() != 0) && out_ready;
      if (advance) begin
        m_dl = loopback_en ? adc_left  : MID;
        m_dr = loopback_en ? adc_right : MID;
      end
      if (flush) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (advance) begin
          if (mq.size() < DEPTH) mq.push_back(exp_sample(adc_left, adc_right));
          else if (m_ovf < 65535) m_ovf++;
        end
      end
      if (mq.size() != 0) m_data = mq[0];
    end
  endtask

  // Advance one clock; model sees the same inputs the DUT sampled.
  task automatic tick();
    @(posedge CLOCK_50);
    model_step();
    #1;
  endtask

  task automatic idle();
    advance = 0; out_ready = 0; flush = 0; reset = 0;
  endtask

  task automatic push_val(input logic [23:0] v);
    advance = 1; adc_left = v; adc_right = v;
    tick();
    advance = 0;
  endtask

  task automatic test_reset();
    reset = 1; advance = 1; adc_left = 24'h55; adc_right = 24'h55;
    tick(); tick();
    idle();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    n_tests++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
    n_tests++; if (overflow_count !== 16'd0) begin n_fail++; $display("FAIL reset_ovf got %0d want 0", overflow_count); end
    n_tests++; if (out_data !== 24'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_data); end
    n_tests++; if (dac_left !== MID || dac_right !== MID) begin n_fail++; $display("FAIL reset_dac got %h/%h want %h", dac_left, dac_right, MID); end
  endtask

  task automatic test_single();
    push_val(24'h123456);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %0b want 1", out_valid); end
    n_tests++; if (out_data !== 24'h123456) begin n_fail++; $display("FAIL single_data got %h want 123456", out_data); end
    n_tests++; if (level !== 5'd1) begin n_fail++; $display("FAIL single_level got %0d want 1", level); end
    out_ready = 1; tick(); out_ready = 0;
    n_tests++; if (out_valid !== 1'b0 || level !== 5'd0) begin n_fail++; $display("FAIL single_pop got valid=%0b level=%0d want 0/0", out_valid, level); end
    n_tests++; if (out_data !== 24'h123456) begin n_fail++; $display("FAIL single_hold got %h want 123456", out_data); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= DEPTH + 3; i++) push_val(24'(i));
    n_tests++; if (level !== 5'd16) begin n_fail++; $display("FAIL fill_level got %0d want 16", level); end
    n_tests++; if (overflow_count !== 16'd3) begin n_fail++; $display("FAIL fill_ovf got %0d want 3", overflow_count); end
    out_ready = 1;
    for (int i = 1; i <= DEPTH; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 24'(i)) begin
        n_fail++; $display("FAIL drain_%0d got valid=%0b data=%h want 1/%h", i, out_valid, out_data, 24'(i));
      end
      tick();
    end
    out_ready = 0;
    n_tests++; if (out_valid !== 1'b0 || level !== 5'd0) begin n_fail++; $display("FAIL drain_empty got valid=%0b level=%0d want 0/0", out_valid, level); end
  endtask

  task automatic test_full_push_pop();
    logic [23:0] last, prev;
    for (int i = 1; i <= DEPTH; i++) push_val(24'(100 + i));
    out_ready = 1; advance = 1; adc_left = 24'hAAAAAA; adc_right = 24'hAAAAAA;
    tick();
    advance = 0;
    n_tests++; if (level !== 5'd16) begin n_fail++; $display("FAIL fullpp_level got %0d want 16", level); end
    n_tests++; if (overflow_count !== 16'd3) begin n_fail++; $display("FAIL fullpp_ovf got %0d want 3", overflow_count); end
    last = '0;
    for (int i = 0; i < DEPTH; i++) begin
      n_tests++;
      if (out_data !== m_data) begin n_fail++; $display("FAIL fullpp_drain_%0d got %h want %h", i, out_data, m_data); end
      last = out_data;
      tick();
    end
    n_tests++; if (last !== 24'hAAAAAA || out_valid !== 1'b0) begin n_fail++; $display("FAIL fullpp_last got %h valid=%0b want AAAAAA/0", last, out_valid); end
    // Steady push+pop at level 1 walks both pointers around the ring.
    prev = 24'h0;
    for (int i = 0; i < 40; i++) begin
      advance = 1; adc_left = 24'($urandom); adc_right = adc_left;
      if (i > 0) begin
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== prev || level !== 5'd1) begin
          n_fail++; $display("FAIL wrap_%0d got %h lvl=%0d want %h lvl=1", i, out_data, level, prev);
        end
      end
      prev = adc_left;
      tick();
    end
    advance = 0; tick(); out_ready = 0;
    n_tests++; if (level !== 5'd0) begin n_fail++; $display("FAIL wrap_end got %0d want 0", level); end
  endtask

  task automatic test_loopback();
    loopback_en = 1; advance = 1; adc_left = 24'h00FF00; adc_right = 24'h0000FF;
    tick(); advance = 0; adc_left = 24'h111111; adc_right = 24'h222222;
    n_tests++; if (dac_left !== 24'h00FF00 || dac_right !== 24'h0000FF) begin n_fail++; $display("FAIL loop_on got %h/%h want 00FF00/0000FF", dac_left, dac_right); end
    tick();
    n_tests++; if (dac_left !== 24'h00FF00 || dac_right !== 24'h0000FF) begin n_fail++; $display("FAIL loop_hold got %h/%h want 00FF00/0000FF", dac_left, dac_right); end
    loopback_en = 0; advance = 1;
    tick(); advance = 0;
    n_tests++; if (dac_left !== MID || dac_right !== MID) begin n_fail++; $display("FAIL loop_off got %h/%h want %h", dac_left, dac_right, MID); end
    flush = 1; tick(); flush = 0;
  endtask

  task automatic test_flush_reset();
    int ovf_before;
    for (int i = 0; i < 5; i++) push_val(24'(i + 7));
    ovf_before = m_ovf;
    flush = 1; advance = 1; adc_left = 24'h77; adc_right = 24'h77;
    tick(); flush = 0; advance = 0;
    n_tests++; if (level !== 5'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush got level=%0d valid=%0b want 0/0", level, out_valid); end
    n_tests++; if (overflow_count !== 16'(ovf_before)) begin n_fail++; $display("FAIL flush_ovf got %0d want %0d", overflow_count, ovf_before); end
    reset = 1; tick(); reset = 0;
    for (int i = 0; i < DEPTH + 2; i++) push_val(24'(i + 1));
    out_ready = 1; for (int i = 0; i < 9; i++) tick(); out_ready = 0;
    n_tests++; if (level !== 5'd7 || overflow_count !== 16'd2) begin n_fail++; $display("FAIL pre_reset got level=%0d ovf=%0d want 7/2", level, overflow_count); end
    reset = 1; advance = 1; loopback_en = 1; tick(); reset = 0; advance = 0; loopback_en = 0;
    n_tests++;
    if (level !== 5'd0 || out_valid !== 1'b0 || overflow_count !== 16'd0 || out_data !== 24'h0 ||
        dac_left !== MID || dac_right !== MID) begin
      n_fail++; $display("FAIL mid_reset got lvl=%0d v=%0b ovf=%0d d=%h dac=%h/%h", level, out_valid,
                         overflow_count, out_data, dac_left, dac_right);
    end
  endtask

  task automatic test_mono();
    advance = 1; adc_left = 24'h000003; adc_right = 24'h000004;
    tick(); advance = 0;
    n_tests++; if (out_data !== 24'h000003) begin n_fail++; $display("FAIL mono_small got %h want 000003", out_data); end
    out_ready = 1; tick(); out_ready = 0;
`ifdef AUDIO_CAPTURE_MONO_MIX_EN
    advance = 1; adc_left = 24'hFFFFFF; adc_right = 24'hFFFFFF;
    tick(); advance = 0;
    n_tests++; if (out_data !== 24'hFFFFFF) begin n_fail++; $display("FAIL mono_max got %h want FFFFFF", out_data); end
    advance = 1; adc_left = 24'h000010; adc_right = 24'h000000; out_ready = 1;
    tick(); advance = 0;
    n_tests++; if (out_data !== 24'h000008) begin n_fail++; $display("FAIL mono_half got %h want 000008", out_data); end
`else
    advance = 1; adc_left = 24'h000010; adc_right = 24'hFFFFFF;
    tick(); advance = 0;
    n_tests++; if (out_data !== 24'h000010) begin n_fail++; $display("FAIL left_only got %h want 000010", out_data); end
`endif
    out_ready = 1; tick(); tick(); out_ready = 0;
  endtask

  task automatic test_random();
    int ready_pct;
    for (int c = 0; c < 3000; c++) begin
      ready_pct = (c < 1500) ? 25 : 60;
      advance     = ($urandom_range(0, 2) == 0);
      out_ready   = ($urandom_range(0, 99) < ready_pct);
      loopback_en = $urandom_range(0, 1);
      flush       = ($urandom_range(0, 99) == 0);
      reset       = ($urandom_range(0, 499) == 0);
      adc_left    = 24'($urandom);
      adc_right   = 24'($urandom);
      tick();
      n_tests++;
      if (out_valid !== (mq.size() != 0) || level !== 5'(mq.size())) begin
        n_fail++; $display("FAIL rnd_occ c=%0d got v=%0b lvl=%0d want lvl=%0d", c, out_valid, level, mq.size());
      end
      n_tests++;
      if (out_data !== m_data) begin n_fail++; $display("FAIL rnd_data c=%0d got %h want %h", c, out_data, m_data); end
      n_tests++;
      if (overflow_count !== 16'(m_ovf)) begin n_fail++; $display("FAIL rnd_ovf c=%0d got %0d want %0d", c, overflow_count, m_ovf); end
      n_tests++;
      if (dac_left !== m_dl || dac_right !== m_dr) begin
        n_fail++; $display("FAIL rnd_dac c=%0d got %h/%h want %h/%h", c, dac_left, dac_right, m_dl, m_dr);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_loopback();
    test_flush_reset();
    test_mono();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
